layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_pkg.sv | 40 ++++
 rtl/layer_sequencer_phase_counter.sv | 58 +++++
 rtl/layer_sequencer.sv | 139 +++++++++++++
 tb/tb_layer_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared layer codes, controller state encoding and default load latency
// for the layer sequencer and its testbench.
package layer_sequencer_pkg;

  typedef enum logic [3:0] {
    LAYER0 = 4'd0,
    LAYER1 = 4'd1,
    LAYER2 = 4'd2,
    LAYER3 = 4'd3,
    AFFINE = 4'd4,
    IDLE   = 4'hF
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  localparam int unsigned LOAD_LAT_DEFAULT = 6;

  // Layer order of one inference pass; IDLE closes the ring back to LAYER0.
  function automatic layer_e next_layer(input layer_e l);
    layer_e n;
    n = IDLE;
    case (l)
      IDLE:    n = LAYER0;
      LAYER0:  n = LAYER1;
      LAYER1:  n = LAYER2;
      LAYER2:  n = LAYER3;
      LAYER3:  n = AFFINE;
      AFFINE:  n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/layer_sequencer_phase_counter.sv
// Layer/phase position counter. clear parks it at IDLE/0; step moves to
// the next phase, wrapping into the next layer after a layer's last phase.
// Stepping out of the final AFFINE phase returns to IDLE.
module layer_phase_counter
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned LAYER_PHASES  = 8,
  parameter int unsigned AFFINE_PHASES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       clear,
  output logic [3:0] cs,
  output logic [2:0] phase,
  output logic       last
);

  localparam logic [2:0] LAST_CONV = 3'(LAYER_PHASES - 1);
  localparam logic [2:0] LAST_AFF  = 3'(AFFINE_PHASES - 1);

  layer_e     r_cs;
  logic [2:0] r_phase;
  logic       w_last;

  // Last-phase flag for the layer currently held.
  always_comb begin
    w_last = 1'b0;
    case (r_cs)
      IDLE:    w_last = 1'b0;
      AFFINE:  w_last = (r_phase == LAST_AFF);
      default: w_last = (r_phase == LAST_CONV);
    endcase
  end

  // Position register: clear wins over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs    <= IDLE;
      r_phase <= '0;
    end else if (clear) begin
      r_cs    <= IDLE;
      r_phase <= '0;
    end else if (step) begin
      if (r_cs == IDLE || w_last) begin
        r_cs    <= next_layer(r_cs);
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 3'd1;
      end
    end
  end

  assign cs    = r_cs;
  assign phase = r_phase;
  assign last  = w_last;

endmodule

// File: rtl/layer_sequencer.sv
// Inference-pass controller: walks LAYER0..LAYER3 and AFFINE phase by phase,
// holding weight load for at least LOAD_LAT cycles before trusting w_valid,
// pulsing conv_start and waiting for conv_done, with a one-cycle load gap
// between phases. All outputs are registers.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned LAYER_PHASES  = 8,
  parameter int unsigned AFFINE_PHASES = 4,
  parameter int unsigned LOAD_LAT      = LOAD_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       w_valid,
  input  logic       conv_done,
  output logic [3:0] cs,
  output logic [2:0] phase,
  output logic       load,
  output logic       conv_start,
  output logic       busy,
  output logic       done
);

  localparam int unsigned  CW     = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LOAD_LAT - 1);

  state_e        r_state;
  logic [CW-1:0] r_ldcnt;
  logic          r_load;
  logic          r_conv_start;
  logic          r_busy;
  logic          r_done;

  logic          w_step;
  logic          w_clear;
  logic          w_last;
  logic [3:0]    w_cs;
  logic [2:0]    w_phase;

  // Counter moves on start (IDLE->LAYER0/0) and on every accepted conv_done,
  // so cs/phase already show the next position in the GAP/DONE cycle.
  always_comb begin
    w_clear = abort;
    w_step  = 1'b0;
    if (!abort) begin
      w_step = ((r_state == S_IDLE) && start) ||
               ((r_state == S_RUN)  && conv_done);
    end
  end

  layer_phase_counter #(
    .LAYER_PHASES  (LAYER_PHASES),
    .AFFINE_PHASES (AFFINE_PHASES)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_step),
    .clear (w_clear),
    .cs    (w_cs),
    .phase (w_phase),
    .last  (w_last)
  );

  // Controller FSM with registered outputs; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ldcnt      <= '0;
      r_load       <= 1'b0;
      r_conv_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      r_done       <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_ldcnt <= '0;
        r_load  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_LOAD;
              r_ldcnt <= '0;
              r_load  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            if ((r_ldcnt >= LAT_M1) && w_valid) begin
              r_state      <= S_RUN;
              r_conv_start <= 1'b1;
            end else if (r_ldcnt < LAT_M1) begin
              r_ldcnt <= r_ldcnt + CW'(1);
            end
          end
          S_RUN: begin
            if (conv_done) begin
              r_load <= 1'b0;
              if (w_last && (w_cs == AFFINE)) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_GAP;
              end
            end
          end
          S_GAP: begin
            r_state <= S_LOAD;
            r_ldcnt <= '0;
            r_load  <= 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_ldcnt <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cs         = w_cs;
  assign phase      = w_phase;
  assign load       = r_load;
  assign conv_start = r_conv_start;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a default-parameter instance driven by a
// 3-cycle conv_done responder, and a 1/1-phase instance whose conv_done is
// returned in the conv_start cycle itself.
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;

  localparam int unsigned LP_A = 8;
  localparam int unsigned AP_A = 4;
  localparam int unsigned LP_B = 1;
  localparam int unsigned AP_B = 1;
  localparam int unsigned LAT  = LOAD_LAT_DEFAULT;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, w_valid, conv_done;
  logic [3:0] cs;
  logic [2:0] phase;
  logic       load, conv_start, busy, done;

  logic       start_b, abort_b, conv_done_b;
  logic [3:0] cs_b;
  logic [2:0] phase_b;
  logic       load_b, conv_start_b, busy_b, done_b;

  always #5 clk = ~clk;

  layer_sequencer #(
    .LAYER_PHASES  (LP_A),
    .AFFINE_PHASES (AP_A),
    .LOAD_LAT      (LAT)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .w_valid    (w_valid),
    .conv_done  (conv_done),
    .cs         (cs),
    .phase      (phase),
    .load       (load),
    .conv_start (conv_start),
    .busy       (busy),
    .done       (done)
  );

  assign conv_done_b = conv_start_b;

  layer_sequencer #(
    .LAYER_PHASES  (LP_B),
    .AFFINE_PHASES (AP_B),
    .LOAD_LAT      (LAT)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .abort      (abort_b),
    .w_valid    (w_valid),
    .conv_done  (conv_done_b),
    .cs         (cs_b),
    .phase      (phase_b),
    .load       (load_b),
    .conv_start (conv_start_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0, rise_cyc = 0, lowcnt = 0, cd = -1, rsp_dly = 3;
  int          n_start_a = 0, n_done_a = 0, n_start_b = 0, n_done_b = 0;
  logic        prev_load = 1'b0, prev_done = 1'b0, prev_cst = 1'b0;
  logic [6:0]  prev_csph = {IDLE, 3'd0};
  bit          hit_l2p2 = 1'b0;
  logic [6:0]  qa[$];
  logic [6:0]  qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected (cs,phase) of every conv_start in one full pass.
  task automatic push_pass(input int unsigned lp, input int unsigned ap, input bit to_b);
    layer_e conv_l[4];
    logic [6:0] e;
    conv_l = '{LAYER0, LAYER1, LAYER2, LAYER3};
    for (int unsigned l = 0; l < 4; l++)
      for (int unsigned p = 0; p < lp; p++) begin
        e = {conv_l[l], 3'(p)};
        if (to_b) qb.push_back(e); else qa.push_back(e);
      end
    for (int unsigned p = 0; p < ap; p++) begin
      e = {AFFINE, 3'(p)};
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  // One clock: sample after the edge, run the per-cycle monitors and the
  // conv_done responder for instance A.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    conv_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        conv_done = 1'b1;
        cd = -1;
      end
    end
    if (load && !prev_load) begin
      if (busy && lowcnt > 0) chk("gap_len", lowcnt, 1);
      rise_cyc = cyc;
      lowcnt = 0;
    end
    if (!busy) lowcnt = 0;
    else if (!load && !done) lowcnt++;
    if ({cs, phase} != prev_csph && prev_csph[6:3] != IDLE && cs != IDLE)
      chk("chg_load", load, 0);
    if (conv_start) begin
      n_start_a++;
      chk("cst_pulse", prev_cst, 0);
      chk("cst_lat", cyc - rise_cyc, LAT);
      chk("sbA_avail", qa.size() != 0, 1);
      if (qa.size() != 0) chk("cst_csph", {cs, phase}, qa.pop_front());
      if (cs == LAYER2 && phase == 3'd2) hit_l2p2 = 1'b1;
      cd = rsp_dly;
      if (cd == 0) begin
        conv_done = 1'b1;
        cd = -1;
      end
    end
    if (done) begin
      n_done_a++;
      chk("done_cs", cs, IDLE);
      chk("done_load", load, 0);
    end
    if (prev_done) chk("busy_fall", busy, 0);
    if (conv_start_b) begin
      n_start_b++;
      chk("b_phase", phase_b, 0);
      chk("sbB_avail", qb.size() != 0, 1);
      if (qb.size() != 0) chk("b_csph", {cs_b, phase_b}, qb.pop_front());
    end
    if (done_b) n_done_b++;
    prev_load = load;
    prev_done = done;
    prev_cst  = conv_start;
    prev_csph = {cs, phase};
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cs"}, cs, IDLE);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_cst"}, conv_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Full pass on A (optionally B too); optionally pulse start mid-pass.
  task automatic run_pass(input bit with_b, input bit busy_start);
    n_start_a = 0; n_done_a = 0; n_start_b = 0; n_done_b = 0;
    push_pass(LP_A, AP_A, 1'b0);
    if (with_b) push_pass(LP_B, AP_B, 1'b1);
    start = 1'b1;
    start_b = with_b;
    tick();
    start = 1'b0;
    start_b = 1'b0;
    chk("pass_first_cs", cs, LAYER0);
    chk("pass_first_load", load, 1);
    for (int i = 0; i < 3000 && !(n_done_a == 1 && (!with_b || n_done_b == 1)); i++) begin
      start = busy_start && (i == 40);
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    chk("pass_starts", n_start_a, 4 * LP_A + AP_A);
    chk("pass_dones", n_done_a, 1);
    chk("pass_sb_left", qa.size(), 0);
    if (with_b) begin
      chk("b_starts", n_start_b, 4 * LP_B + AP_B);
      chk("b_dones", n_done_b, 1);
      chk("b_sb_left", qb.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b1; conv_done = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    repeat (2) tick();
    check_idle("rst");
    rst_n = 1'b1;
    repeat (2) tick();
    check_idle("idle");

    // Full pass on both instances, with a start pulse injected while busy.
    run_pass(1'b1, 1'b1);

    // Abort together with conv_done in the 3rd RUN of LAYER2.
    n_start_a = 0; n_done_a = 0; hit_l2p2 = 1'b0;
    push_pass(LP_A, AP_A, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3000 && !hit_l2p2; i++) tick();
    chk("l2p2_reached", hit_l2p2, 1);
    abort = 1'b1;
    conv_done = 1'b1;
    cd = -1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    repeat (20) tick();
    chk("abort_nodone", n_done_a, 0);
    chk("abort_starts", n_start_a, 2 * LP_A + 3);
    qa.delete();

    // Restart after abort begins again at LAYER0 phase 0 and completes.
    run_pass(1'b0, 1'b0);

    // Abort in the last LOAD cycle suppresses the conv_start.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lload_load", load, 1);
    repeat (LAT - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("lload");

    // Asynchronous reset mid-LOAD; no done and no restart without start.
    n_done_a = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    cd = -1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_idle("post_rst");
    chk("post_rst_nodone", n_done_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
